// File: rtl/legv8_ctrl_pkg.sv
// Shared types and encodings for the LEGv8 multicycle control path and the ALU control decoder.
// ILLEGAL_TRAP_EN adds the absorbing TRAP state for undecoded opcodes.
package legv8_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEM_ADDR,
        MEM_RD,
        MEM_WB,
        MEM_WR,
        R_EXEC,
        R_WB,
        BRANCH
`ifdef ILLEGAL_TRAP_EN
        , TRAP
`endif
    } state_t;

    localparam logic [10:0] OP_LDUR    = 11'b11111000010;
    localparam logic [10:0] OP_STUR    = 11'b11111000000;
    localparam logic [10:0] OP_ADD     = 11'b10001011000;
    localparam logic [10:0] OP_SUB     = 11'b11001011000;
    localparam logic [10:0] OP_AND     = 11'b10001010000;
    localparam logic [10:0] OP_ORR     = 11'b10101010000;
    localparam logic [7:0]  OP_CBZ_PFX = 8'b10110100;
    localparam logic [5:0]  OP_B_PFX   = 6'b000101;

    localparam logic [1:0] ALUSRCB_B       = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
    localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_PASSB = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic mem_ld;
        logic mem_st;
        logic rtype;
        logic cbz;
        logic b;
        logic illegal;
    } opclass_t;

endpackage

// File: rtl/multicycle_ctrl_opclass_dec.sv
// One-hot opcode class decode of IR[31:21]; purely combinational so the
// single-cycle core can reuse it unchanged.
module opclass_dec
    import legv8_ctrl_pkg::*;
(
    input  logic [10:0] op,
    output opclass_t    cls
);

    always_comb begin
        cls = '0;
        if (op == OP_LDUR) begin
            cls.mem_ld = 1'b1;
        end else if (op == OP_STUR) begin
            cls.mem_st = 1'b1;
        end else if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_ORR) begin
            cls.rtype = 1'b1;
        end else if (op[10:3] == OP_CBZ_PFX) begin
            cls.cbz = 1'b1;
        end else if (op[10:5] == OP_B_PFX) begin
            cls.b = 1'b1;
        end else begin
            cls.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle LEGv8 core plus the instructions-retired counter.
// Define ILLEGAL_TRAP_EN to trap undecoded opcodes instead of treating them as NOPs.
module multicycle_ctrl
    import legv8_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [10:0]      op,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             pc_src,
    output logic             ir_write,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg2loc,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       aluop,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

`ifdef ILLEGAL_TRAP_EN
    localparam state_t UNDEF_NEXT = TRAP;
`else
    localparam state_t UNDEF_NEXT = FETCH;
`endif

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] instret_reg;
    logic             retire;
    opclass_t         cls;

    // zero is qualified by pc_write_cond in the datapath, not here.
    logic unused_zero;
    assign unused_zero = zero;

    opclass_dec u_dec (
        .op  (op),
        .cls (cls)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= FETCH;
            instret_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (retire) begin
                instret_reg <= instret_reg + CNT_W'(1);
            end
        end
    end

    assign instret = instret_reg;

    always_comb begin
        state_next    = state_reg;
        retire        = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = 1'b0;
        ir_write      = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        reg2loc       = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = ALUSRCB_B;
        aluop         = ALUOP_ADD;
        illegal       = 1'b0;

        case (state_reg)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = ALUSRCB_FOUR;
                if (mem_ready) begin
                    // Gated by reset so no register loads while reset is held.
                    ir_write   = reset;
                    pc_write   = reset;
                    state_next = DECODE;
                end
            end
            DECODE: begin
                alu_src_b = ALUSRCB_IMM_SH2;
                reg2loc   = cls.mem_st | cls.cbz;
                if (cls.mem_ld || cls.mem_st) begin
                    state_next = MEM_ADDR;
                end else if (cls.rtype) begin
                    state_next = R_EXEC;
                end else if (cls.cbz || cls.b) begin
                    state_next = BRANCH;
                end else if (cls.illegal) begin
                    state_next = UNDEF_NEXT;
                end else begin
                    state_next = FETCH;
                end
            end
            MEM_ADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = ALUSRCB_IMM;
                state_next = cls.mem_ld ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                if (mem_ready) begin
                    state_next = MEM_WB;
                end
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_next = FETCH;
            end
            MEM_WR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                reg2loc   = 1'b1;
                if (mem_ready) begin
                    retire     = 1'b1;
                    state_next = FETCH;
                end
            end
            R_EXEC: begin
                alu_src_a  = 1'b1;
                aluop      = ALUOP_FUNCT;
                state_next = R_WB;
            end
            R_WB: begin
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_next = FETCH;
            end
            BRANCH: begin
                pc_src = 1'b1;
                if (cls.cbz) begin
                    alu_src_a     = 1'b1;
                    aluop         = ALUOP_PASSB;
                    reg2loc       = 1'b1;
                    pc_write_cond = 1'b1;
                end else begin
                    pc_write = 1'b1;
                end
                retire     = 1'b1;
                state_next = FETCH;
            end
`ifdef ILLEGAL_TRAP_EN
            TRAP: begin
                illegal    = 1'b1;
                state_next = TRAP;
            end
`endif
            default: begin
                state_next = FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected control words and counter values
// are queued with the stimulus and checked as each cycle is executed.
module tb_multicycle_ctrl;

    // Control word layout: {pc_write, pc_write_cond, pc_src, ir_write, iord, mem_read,
    // mem_write, reg2loc, reg_write, mem_to_reg, alu_src_a, alu_src_b[1:0], aluop[1:0], illegal}
    localparam logic [15:0] C_FETCH_WAIT = 16'h0408;
    localparam logic [15:0] C_FETCH_GO   = 16'h9408;
    localparam logic [15:0] C_DECODE     = 16'h0018;
    localparam logic [15:0] C_DECODE_R2L = 16'h0118;
    localparam logic [15:0] C_MEM_ADDR   = 16'h0030;
    localparam logic [15:0] C_MEM_RD     = 16'h0C00;
    localparam logic [15:0] C_MEM_WB     = 16'h00C0;
    localparam logic [15:0] C_MEM_WR     = 16'h0B00;
    localparam logic [15:0] C_R_EXEC     = 16'h0024;
    localparam logic [15:0] C_R_WB       = 16'h0080;
    localparam logic [15:0] C_BR_CBZ     = 16'h6122;
    localparam logic [15:0] C_BR_B       = 16'hA000;
    localparam logic [15:0] C_TRAP       = 16'h0001;

    typedef struct {
        logic        mr;
        logic [15:0] ctl;
        logic [3:0]  cnt;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] op;
    logic        zero;
    logic        mem_ready;
    logic        pc_write, pc_write_cond, pc_src, ir_write, iord, mem_read, mem_write;
    logic        reg2loc, reg_write, mem_to_reg, alu_src_a, illegal;
    logic [1:0]  alu_src_b, aluop;
    logic [3:0]  instret;
    logic [15:0] ctl;

    ent_t        sb[$];
    ent_t        e;
    logic [3:0]  exp_cnt;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.CNT_W(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .op            (op),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_src        (pc_src),
        .ir_write      (ir_write),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .reg2loc       (reg2loc),
        .reg_write     (reg_write),
        .mem_to_reg    (mem_to_reg),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .aluop         (aluop),
        .illegal       (illegal),
        .instret       (instret)
    );

    assign ctl = {pc_write, pc_write_cond, pc_src, ir_write, iord, mem_read, mem_write,
                  reg2loc, reg_write, mem_to_reg, alu_src_a, alu_src_b, aluop, illegal};

    task automatic push(input logic mr, input logic [15:0] c);
        ent_t n;
        n.mr  = mr;
        n.ctl = c;
        n.cnt = exp_cnt;
        sb.push_back(n);
    endtask

    task automatic push_b();
        push(1'b1, C_FETCH_GO);
        push(1'b1, C_DECODE);
        push(1'b1, C_BR_B);
        exp_cnt = exp_cnt + 4'd1;
    endtask

    task automatic test_reset();
        reset = 1'b0; mem_ready = 1'b1; op = 11'd0; zero = 1'b0; exp_cnt = 4'd0;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (ctl !== C_FETCH_WAIT || instret !== 4'd0) begin
            bad++;
            $display("FAIL reset_state: ctl=%h instret=%0d expected ctl=%h instret=0", ctl, instret, C_FETCH_WAIT);
        end
        @(negedge clk);
        mem_ready = 1'b0;
        reset = 1'b1;
        #1;
        total++;
        if (ctl !== C_FETCH_WAIT || instret !== 4'd0) begin
            bad++;
            $display("FAIL reset_release: ctl=%h instret=%0d expected ctl=%h instret=0", ctl, instret, C_FETCH_WAIT);
        end
    endtask

    task automatic test_rtype();
        logic [10:0] ops [4];
        ops[0] = 11'b10001011000; ops[1] = 11'b11001011000;
        ops[2] = 11'b10001010000; ops[3] = 11'b10101010000;
        for (int k = 0; k < 4; k++) begin
            op = ops[k];
            push(1'b1, C_FETCH_GO);
            push(1'b1, C_DECODE);
            push(1'b1, C_R_EXEC);
            push(1'b1, C_R_WB);
            exp_cnt = exp_cnt + 4'd1;
            while (sb.size() != 0) begin
                e = sb.pop_front();
                @(negedge clk); mem_ready = e.mr; #1;
                total++;
                if (ctl !== e.ctl || instret !== e.cnt) begin
                    bad++;
                    $display("FAIL rtype op=%b: ctl=%h instret=%0d expected ctl=%h instret=%0d", op, ctl, instret, e.ctl, e.cnt);
                end
            end
        end
    endtask

    task automatic test_ldur_wait();
        op = 11'b11111000010;
        push(1'b1, C_FETCH_GO);
        push(1'b1, C_DECODE);
        push(1'b1, C_MEM_ADDR);
        push(1'b0, C_MEM_RD);
        push(1'b0, C_MEM_RD);
        push(1'b0, C_MEM_RD);
        push(1'b1, C_MEM_RD);
        push(1'b0, C_MEM_WB);
        exp_cnt = exp_cnt + 4'd1;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            @(negedge clk); mem_ready = e.mr; #1;
            total++;
            if (ctl !== e.ctl || instret !== e.cnt) begin
                bad++;
                $display("FAIL ldur_wait: ctl=%h instret=%0d expected ctl=%h instret=%0d", ctl, instret, e.ctl, e.cnt);
            end
        end
    endtask

    task automatic test_stur_wait();
        op = 11'b11111000000;
        push(1'b0, C_FETCH_WAIT);
        push(1'b0, C_FETCH_WAIT);
        push(1'b1, C_FETCH_GO);
        push(1'b0, C_DECODE_R2L);
        push(1'b0, C_MEM_ADDR);
        push(1'b0, C_MEM_WR);
        push(1'b1, C_MEM_WR);
        exp_cnt = exp_cnt + 4'd1;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            @(negedge clk); mem_ready = e.mr; #1;
            total++;
            if (ctl !== e.ctl || instret !== e.cnt) begin
                bad++;
                $display("FAIL stur_wait: ctl=%h instret=%0d expected ctl=%h instret=%0d", ctl, instret, e.ctl, e.cnt);
            end
        end
    endtask

    task automatic test_branch();
        for (int k = 0; k < 2; k++) begin
            op = 11'b10110100101;
            zero = (k == 0);
            push(1'b1, C_FETCH_GO);
            push(1'b1, C_DECODE_R2L);
            push(1'b1, C_BR_CBZ);
            exp_cnt = exp_cnt + 4'd1;
            while (sb.size() != 0) begin
                e = sb.pop_front();
                @(negedge clk); mem_ready = e.mr; #1;
                total++;
                if (ctl !== e.ctl || instret !== e.cnt) begin
                    bad++;
                    $display("FAIL cbz zero=%0d: ctl=%h instret=%0d expected ctl=%h instret=%0d", zero, ctl, instret, e.ctl, e.cnt);
                end
            end
        end
        op = 11'b00010110011;
        push_b();
        while (sb.size() != 0) begin
            e = sb.pop_front();
            @(negedge clk); mem_ready = e.mr; #1;
            total++;
            if (ctl !== e.ctl || instret !== e.cnt) begin
                bad++;
                $display("FAIL b: ctl=%h instret=%0d expected ctl=%h instret=%0d", ctl, instret, e.ctl, e.cnt);
            end
        end
    endtask

    task automatic test_back_to_back_wrap();
        op = 11'b00010100000;
        while (exp_cnt != 4'd0) push_b();
        push(1'b0, C_FETCH_WAIT);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            @(negedge clk); mem_ready = e.mr; #1;
            total++;
            if (ctl !== e.ctl || instret !== e.cnt) begin
                bad++;
                $display("FAIL wrap: ctl=%h instret=%0d expected ctl=%h instret=%0d", ctl, instret, e.ctl, e.cnt);
            end
        end
    endtask

    task automatic test_illegal();
        op = 11'b11111111111;
        push(1'b1, C_FETCH_GO);
        push(1'b1, C_DECODE);
`ifdef ILLEGAL_TRAP_EN
        push(1'b1, C_TRAP);
        push(1'b1, C_TRAP);
        push(1'b1, C_TRAP);
`else
        push(1'b0, C_FETCH_WAIT);
`endif
        while (sb.size() != 0) begin
            e = sb.pop_front();
            @(negedge clk); mem_ready = e.mr; #1;
            total++;
            if (ctl !== e.ctl || instret !== e.cnt) begin
                bad++;
                $display("FAIL illegal: ctl=%h instret=%0d expected ctl=%h instret=%0d", ctl, instret, e.ctl, e.cnt);
            end
        end
    endtask

    task automatic test_reset_abort();
        @(negedge clk); reset = 1'b0; mem_ready = 1'b0;
        @(negedge clk); reset = 1'b1;
        exp_cnt = 4'd0;
        op = 11'b10001011000;
        push(1'b1, C_FETCH_GO);
        push(1'b1, C_DECODE);
        push(1'b1, C_R_EXEC);
        push(1'b1, C_R_WB);
        exp_cnt = exp_cnt + 4'd1;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            @(negedge clk); mem_ready = e.mr; #1;
            total++;
            if (ctl !== e.ctl || instret !== e.cnt) begin
                bad++;
                $display("FAIL abort_add: ctl=%h instret=%0d expected ctl=%h instret=%0d", ctl, instret, e.ctl, e.cnt);
            end
        end
        op = 11'b11111000000;
        push(1'b1, C_FETCH_GO);
        push(1'b1, C_DECODE_R2L);
        push(1'b1, C_MEM_ADDR);
        push(1'b0, C_MEM_WR);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            @(negedge clk); mem_ready = e.mr; #1;
            total++;
            if (ctl !== e.ctl || instret !== e.cnt) begin
                bad++;
                $display("FAIL abort_stur: ctl=%h instret=%0d expected ctl=%h instret=%0d", ctl, instret, e.ctl, e.cnt);
            end
        end
        #1; reset = 1'b0; #1;
        total++;
        if (mem_write !== 1'b0 || ctl !== C_FETCH_WAIT || instret !== 4'd0) begin
            bad++;
            $display("FAIL abort_async: mem_write=%b ctl=%h instret=%0d expected mem_write=0 ctl=%h instret=0", mem_write, ctl, instret, C_FETCH_WAIT);
        end
        mem_ready = 1'b1;
        @(negedge clk); #1;
        total++;
        if (ctl !== C_FETCH_WAIT || instret !== 4'd0) begin
            bad++;
            $display("FAIL abort_hold: ctl=%h instret=%0d expected ctl=%h instret=0", ctl, instret, C_FETCH_WAIT);
        end
        @(negedge clk); reset = 1'b1; #1;
        total++;
        if (ctl !== C_FETCH_GO || instret !== 4'd0) begin
            bad++;
            $display("FAIL abort_release: ctl=%h instret=%0d expected ctl=%h instret=0", ctl, instret, C_FETCH_GO);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_ldur_wait();
        test_stur_wait();
        test_branch();
        test_back_to_back_wrap();
        test_illegal();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
